// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the writeback register file and its pending-write
// scoreboard: widths, the hard-wired zero register index and common types.
package regfile_scoreboard_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 2;
  localparam int NREGS   = 2 ** ADDR_W;
  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_idx_t REG_ZERO  = '0;
  localparam cnt_t     CNT_ONE   = cnt_t'(1);
  localparam cnt_t     CNT_LIMIT = cnt_t'(CNT_MAX);

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of writeback, decode-read and issue signals between the pipeline
// (master) and the register file / scoreboard (slave).
//   WriteData/WriteReg/RegWrite : writeback commit from WB
//   ReadReg1/2, Src1/2Used      : decode source operands
//   IssueValid/Writes/Reg       : decode issue and destination reservation
//   ReadData1/2, Stall          : operand values and decode hold
//   ErrUnderflow                : sticky release-without-reservation flag
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  data_t    WriteData;
  reg_idx_t WriteReg;
  logic     RegWrite;
  reg_idx_t ReadReg1;
  reg_idx_t ReadReg2;
  logic     Src1Used;
  logic     Src2Used;
  logic     IssueValid;
  logic     IssueWrites;
  reg_idx_t IssueReg;
  data_t    ReadData1;
  data_t    ReadData2;
  logic     Stall;
  logic     ErrUnderflow;

  modport master (
    output WriteData, WriteReg, RegWrite, ReadReg1, ReadReg2, Src1Used,
           Src2Used, IssueValid, IssueWrites, IssueReg,
    input  ReadData1, ReadData2, Stall, ErrUnderflow
  );

  modport slave (
    input  WriteData, WriteReg, RegWrite, ReadReg1, ReadReg2, Src1Used,
           Src2Used, IssueValid, IssueWrites, IssueReg,
    output ReadData1, ReadData2, Stall, ErrUnderflow
  );

endinterface

// File: rtl/regfile_scoreboard_wb_scoreboard.sv
// Per-register in-flight write counters. Issue reserves a destination,
// writeback releases it; decode stalls on sources still in flight or when a
// destination counter is saturated.
//   clk, reset        : clock, synchronous active-high reset
//   we, write_reg     : effective writeback (already excludes register 0)
//   issue_*           : decode issue request and destination
//   read_reg*, src*_used : decode source operands
//   stall             : decode hold, combinational
//   err_underflow     : sticky, set when a release finds no reservation
module wb_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     we,
  input  reg_idx_t write_reg,
  input  logic     issue_valid,
  input  logic     issue_writes,
  input  reg_idx_t issue_reg,
  input  reg_idx_t read_reg1,
  input  reg_idx_t read_reg2,
  input  logic     src1_used,
  input  logic     src2_used,
  output logic     stall,
  output logic     err_underflow
);

  cnt_t             cnt [NREGS];
  logic [NREGS-1:0] underflow;
  logic             iss;
  logic             haz1, haz2, dst_full;

  // Register 0 is never reserved, so its counter is a constant zero.
  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    cnt_t cnt_r;
    logic iss_hit, ret_hit;

    assign iss_hit      = iss && (issue_reg == reg_idx_t'(g));
    assign ret_hit      = we && (write_reg == reg_idx_t'(g));
    assign underflow[g] = ret_hit && !iss_hit && (cnt_r == '0);
    assign cnt[g]       = cnt_r;

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples the pre-edge values of its neighbours and of the inputs.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_r <= '0;
      end else if (iss_hit && !ret_hit) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else if (ret_hit && !iss_hit && cnt_r != '0) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // A source whose last in-flight write lands this cycle is served by the
  // read bypass, so only older outstanding writes stall decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    haz1     = 1'b0;
    haz2     = 1'b0;
    dst_full = 1'b0;
    if (src1_used && read_reg1 != REG_ZERO)
      haz1 = (cnt[read_reg1] > CNT_ONE) ||
             (cnt[read_reg1] == CNT_ONE && !(we && write_reg == read_reg1));
    if (src2_used && read_reg2 != REG_ZERO)
      haz2 = (cnt[read_reg2] > CNT_ONE) ||
             (cnt[read_reg2] == CNT_ONE && !(we && write_reg == read_reg2));
    if (issue_writes)
      dst_full = (cnt[issue_reg] == CNT_LIMIT) && !(we && write_reg == issue_reg);
  end

  assign stall = issue_valid && (haz1 || haz2 || dst_full);
  assign iss   = issue_valid && issue_writes && (issue_reg != REG_ZERO) && !stall;

  always_ff @(posedge clk) begin
    if (reset)
      err_underflow <= 1'b0;
    else if (|underflow)
      err_underflow <= 1'b1;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file at the consumer end of writeback, with two
// combinational read ports, same-cycle write-to-read bypass and a pending
// write scoreboard that stalls decode on in-flight sources.
//   clk, reset : clock, synchronous active-high reset (wins over all updates)
//   bus        : slave side of regfile_scoreboard_if (writeback, read, issue)
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  data_t rf [NREGS];
  logic  we;

  // Writes to register 0 are dropped here, so they neither commit nor retire.
  assign we = bus.RegWrite && (bus.WriteReg != REG_ZERO);

  // NOTE: the array is cleared on reset because software relies on every
  // register reading zero afterwards; this costs a reset on each entry.
  always_ff @(posedge clk) begin
    if (reset)
      rf <= '{default: '0};
    else if (we)
      rf[bus.WriteReg] <= bus.WriteData;
  end

  always_comb begin
    bus.ReadData1 = '0;
    if (bus.ReadReg1 != REG_ZERO)
      bus.ReadData1 = (we && bus.WriteReg == bus.ReadReg1) ? bus.WriteData
                                                           : rf[bus.ReadReg1];
    bus.ReadData2 = '0;
    if (bus.ReadReg2 != REG_ZERO)
      bus.ReadData2 = (we && bus.WriteReg == bus.ReadReg2) ? bus.WriteData
                                                           : rf[bus.ReadReg2];
  end

  wb_scoreboard u_sb (
    .clk           (clk),
    .reset         (reset),
    .we            (we),
    .write_reg     (bus.WriteReg),
    .issue_valid   (bus.IssueValid),
    .issue_writes  (bus.IssueWrites),
    .issue_reg     (bus.IssueReg),
    .read_reg1     (bus.ReadReg1),
    .read_reg2     (bus.ReadReg2),
    .src1_used     (bus.Src1Used),
    .src2_used     (bus.Src2Used),
    .stall         (bus.Stall),
    .err_underflow (bus.ErrUnderflow)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench for regfile_scoreboard. Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns later, well away from the next edge.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.WriteData = '0; bus.WriteReg = '0; bus.RegWrite = 1'b0;
    bus.ReadReg1 = '0; bus.ReadReg2 = '0; bus.Src1Used = 1'b0; bus.Src2Used = 1'b0;
    bus.IssueValid = 1'b0; bus.IssueWrites = 1'b0; bus.IssueReg = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input reg_idx_t r);
    bus.IssueValid = 1'b1; bus.IssueWrites = 1'b1; bus.IssueReg = r;
  endtask

  task automatic wb(input reg_idx_t r, input data_t d);
    bus.RegWrite = 1'b1; bus.WriteReg = r; bus.WriteData = d;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd31; bus.Src1Used = 1'b1; bus.Src2Used = 1'b1;
    bus.IssueValid = 1'b1;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h expected 0", bus.ReadData1); end
    checks++; if (bus.ReadData2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h expected 0", bus.ReadData2); end
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.ErrUnderflow); end
    idle();
  endtask

  task automatic test_bypass();
    apply_reset();
    wb(5'd5, 32'hDEADBEEF);
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd5;
    settle();
    checks++; if (bus.ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1: got %h expected deadbeef", bus.ReadData1); end
    checks++; if (bus.ReadData2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd2: got %h expected deadbeef", bus.ReadData2); end
    tick();
    bus.RegWrite = 1'b0;
    settle();
    checks++; if (bus.ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_rd1: got %h expected deadbeef", bus.ReadData1); end
    // Reg 5 was never reserved, so this writeback is an underflow.
    checks++; if (bus.ErrUnderflow !== 1'b1) begin errors++; $display("FAIL bypass_err: got %b expected 1", bus.ErrUnderflow); end
    idle();
  endtask

  task automatic test_reg_zero();
    apply_reset();
    wb(5'd0, 32'h1234);
    bus.ReadReg1 = 5'd0; bus.Src1Used = 1'b1; bus.IssueValid = 1'b1;
    settle();
    checks++; if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", bus.ReadData1); end
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b expected 0", bus.Stall); end
    tick();
    bus.RegWrite = 1'b0;
    issue(5'd0);
    settle();
    checks++; if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL r0_array: got %h expected 0", bus.ReadData1); end
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL r0_err: got %b expected 0", bus.ErrUnderflow); end
    tick();
    // Issuing to reg 0 reserved nothing, so reading it still does not stall.
    bus.IssueWrites = 1'b0;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL r0_noreserve: got %b expected 0", bus.Stall); end
    idle();
  endtask

  task automatic test_raw_hazard();
    apply_reset();
    issue(5'd7);
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL raw_issue: got %b expected 0", bus.Stall); end
    tick();
    bus.IssueWrites = 1'b0; bus.Src1Used = 1'b1; bus.ReadReg1 = 5'd7;
    settle();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL raw_stall1: got %b expected 1", bus.Stall); end
    bus.Src1Used = 1'b0;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL raw_unused: got %b expected 0", bus.Stall); end
    bus.Src2Used = 1'b1; bus.ReadReg2 = 5'd7;
    settle();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL raw_stall2: got %b expected 1", bus.Stall); end
    bus.IssueValid = 1'b0;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL raw_novalid: got %b expected 0", bus.Stall); end
    bus.IssueValid = 1'b1; bus.Src2Used = 1'b0; bus.Src1Used = 1'b1;
    tick();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL raw_hold: got %b expected 1", bus.Stall); end
    wb(5'd7, 32'hA5);
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData1 !== 32'hA5) begin errors++; $display("FAIL raw_rd1: got %h expected a5", bus.ReadData1); end
    tick();
    bus.RegWrite = 1'b0;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL raw_after: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData1 !== 32'hA5) begin errors++; $display("FAIL raw_array: got %h expected a5", bus.ReadData1); end
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL raw_err: got %b expected 0", bus.ErrUnderflow); end
    idle();
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      issue(5'd3);
      settle();
      checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL ovf_fill%0d: got %b expected 0", i, bus.Stall); end
      tick();
    end
    issue(5'd3);
    settle();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", bus.Stall); end
    tick();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", bus.Stall); end
    wb(5'd3, 32'h33);
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL ovf_swap: got %b expected 0", bus.Stall); end
    tick();
    // Issue and retire cancelled, so the counter must still be at its maximum.
    bus.RegWrite = 1'b0;
    settle();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %b expected 1", bus.Stall); end
    idle();
    bus.IssueValid = 1'b1; bus.Src1Used = 1'b1; bus.ReadReg1 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      wb(5'd3, 32'h40 + data_t'(i));
      settle();
      checks++; if (bus.Stall !== (i == 2 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL ovf_drain%0d: got %b expected %b", i, bus.Stall, (i == 2 ? 1'b0 : 1'b1)); end
      tick();
    end
    bus.RegWrite = 1'b0;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData1 !== 32'h42) begin errors++; $display("FAIL ovf_data: got %h expected 42", bus.ReadData1); end
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL ovf_err: got %b expected 0", bus.ErrUnderflow); end
    idle();
  endtask

  task automatic test_underflow();
    apply_reset();
    wb(5'd9, 32'h99);
    settle();
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL uf_pre: got %b expected 0", bus.ErrUnderflow); end
    tick();
    idle();
    bus.ReadReg2 = 5'd9;
    settle();
    checks++; if (bus.ErrUnderflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", bus.ErrUnderflow); end
    checks++; if (bus.ReadData2 !== 32'h99) begin errors++; $display("FAIL uf_data: got %h expected 99", bus.ReadData2); end
    tick();
    checks++; if (bus.ErrUnderflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", bus.ErrUnderflow); end
    // Reset wins over a same-cycle write.
    reset = 1'b1;
    wb(5'd9, 32'h77);
    tick();
    reset = 1'b0;
    idle();
    bus.ReadReg2 = 5'd9;
    settle();
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL uf_cleared: got %b expected 0", bus.ErrUnderflow); end
    checks++; if (bus.ReadData2 !== 32'h0) begin errors++; $display("FAIL uf_rd_reset: got %h expected 0", bus.ReadData2); end
    idle();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    issue(5'd4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    bus.IssueValid = 1'b1; bus.Src1Used = 1'b1; bus.ReadReg1 = 5'd4;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL mid_rd1: got %h expected 0", bus.ReadData1); end
    idle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    // Issue and retire to an empty counter in one cycle: no change, no error.
    issue(5'd10);
    wb(5'd10, 32'hAAAA);
    tick();
    idle();
    bus.IssueValid = 1'b1; bus.Src2Used = 1'b1; bus.ReadReg2 = 5'd10;
    settle();
    checks++; if (bus.ErrUnderflow !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", bus.ErrUnderflow); end
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData2 !== 32'hAAAA) begin errors++; $display("FAIL b2b_rd2: got %h expected aaaa", bus.ReadData2); end
    // Two back-to-back issues to reg 12: one retire is not enough to unstall.
    idle();
    issue(5'd12);
    tick();
    tick();
    bus.IssueWrites = 1'b0; bus.Src1Used = 1'b1; bus.ReadReg1 = 5'd12;
    wb(5'd12, 32'h1212);
    settle();
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL b2b_two: got %b expected 1", bus.Stall); end
    tick();
    bus.WriteData = 32'h3434;
    settle();
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL b2b_last: got %b expected 0", bus.Stall); end
    checks++; if (bus.ReadData1 !== 32'h3434) begin errors++; $display("FAIL b2b_rd1: got %h expected 3434", bus.ReadData1); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_bypass();
    test_reg_zero();
    test_raw_hazard();
    test_overflow();
    test_underflow();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
